// File: rtl/lab_pkg.sv
// Shared definitions for the LAB readout sequencer: channel state encoding
// and the timeout counter width.
package lab_pkg;

    localparam int TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_ADC  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } lab_state_e;

endpackage

// File: rtl/lab_chan_fsm.sv
// Per-channel event lifecycle: hold/digitize/convert/readout/done/ack,
// with a timeout supervisor and sticky error flags.
module lab_chan_fsm
    import lab_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       digitize_i,
    input  logic       grant_i,
    input  logic       adc_done_i,
    input  logic       readout_done_i,
    input  logic       ack_i,
    output lab_state_e state_o,
    output logic       busy_nxt_o,
    output logic       adc_start_o,
    output logic       readout_o,
    output logic       done_o,
    output logic       nrun_o,
    output logic       timeout_o,
    output logic       overrun_o
);

    // Abort fires on the cycle whose increment would reach TIMEOUT_CYC, so
    // DONE and the timeout flag appear exactly TIMEOUT_CYC cycles after entry.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    lab_state_e           state;
    lab_state_e           state_nxt;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_nxt;
    logic                 adc_start_nxt;
    logic                 readout_nxt;
    logic                 timeout_set;
    logic                 overrun_set;
    logic                 flag_clr;

    assign state_o    = state;
    assign busy_nxt_o = (state_nxt != ST_IDLE);

    // State and timeout counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter, pulse and flag-update decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        adc_start_nxt = 1'b0;
        readout_nxt   = 1'b0;
        timeout_set   = 1'b0;
        overrun_set   = 1'b0;
        flag_clr      = ack_i;
        case (state)
            ST_IDLE: begin
                if (digitize_i) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                overrun_set = digitize_i;
                if (grant_i) begin
                    state_nxt     = ST_ADC;
                    adc_start_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            ST_ADC: begin
                overrun_set = digitize_i;
                if (adc_done_i) begin
                    state_nxt   = ST_READ;
                    readout_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_DONE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + TIMEOUT_W'(1);
                end
            end
            ST_READ: begin
                overrun_set = digitize_i;
                if (readout_done_i) begin
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_DONE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + TIMEOUT_W'(1);
                end
            end
            ST_DONE: begin
                // A re-arm takes priority and swallows a simultaneous ack.
                if (digitize_i) begin
                    state_nxt = ST_PEND;
                    flag_clr  = 1'b0;
                end else if (ack_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered channel outputs; done_o tracks the state it is entering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adc_start_o <= 1'b0;
            readout_o   <= 1'b0;
            done_o      <= 1'b0;
            nrun_o      <= 1'b0;
            timeout_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            adc_start_o <= adc_start_nxt;
            readout_o   <= readout_nxt;
            done_o      <= (state_nxt == ST_DONE);
            nrun_o      <= hold_i | (state == ST_PEND) | (state == ST_ADC);
            timeout_o   <= timeout_set | (timeout_o & ~flag_clr);
            overrun_o   <= overrun_set | (overrun_o & ~flag_clr);
        end
    end

endmodule

// File: rtl/lab_readout_sequencer.sv
// NUM_LAB-channel readout sequencer: per-channel lifecycle FSMs, round-robin
// ADC arbitration and a pipelined readback mux onto one 32-bit port.
module lab_readout_sequencer
    import lab_pkg::*;
#(
    parameter int NUM_LAB     = 4,
    parameter int CH_W        = 2,
    parameter int RAM_AW      = 11,
    parameter int SHARED_ADC  = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_LAB-1:0]      hold_i,
    input  logic [NUM_LAB-1:0]      digitize_i,
    output logic [NUM_LAB-1:0]      adc_start_o,
    input  logic [NUM_LAB-1:0]      adc_done_i,
    output logic [NUM_LAB-1:0]      readout_o,
    input  logic [NUM_LAB-1:0]      readout_done_i,
    output logic [NUM_LAB-1:0]      nrun_o,
    output logic [RAM_AW-1:0]       ram_raddr_o,
    input  logic [32*NUM_LAB-1:0]   ram_dat_i,
    input  logic [CH_W+RAM_AW-1:0]  addr_i,
    input  logic                    rd_i,
    output logic [31:0]             dat_o,
    output logic                    dat_valid_o,
    output logic [NUM_LAB-1:0]      done_o,
    input  logic [NUM_LAB-1:0]      ack_i,
    output logic                    busy_o,
    output logic [NUM_LAB-1:0]      timeout_o,
    output logic [NUM_LAB-1:0]      overrun_o
);

    lab_state_e          chan_state [NUM_LAB];
    logic [NUM_LAB-1:0]  chan_busy_nxt;
    logic [NUM_LAB-1:0]  grant;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     rr_nxt;
    logic                any_active;
    int                  best;
    int                  best_d;
    logic [CH_W-1:0]     sel_p1;
    logic                vld_p1;
    logic [31:0]         rd_word_p1;

    // Distance of channel j from the round-robin pointer, wrapping at NUM_LAB.
    function automatic int rr_dist(input int j, input logic [CH_W-1:0] ptr);
        return (j - int'(ptr) + NUM_LAB) % NUM_LAB;
    endfunction

    for (genvar k = 0; k < NUM_LAB; k++) begin : g_chan
        lab_chan_fsm #(
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .hold_i         (hold_i[k]),
            .digitize_i     (digitize_i[k]),
            .grant_i        (grant[k]),
            .adc_done_i     (adc_done_i[k]),
            .readout_done_i (readout_done_i[k]),
            .ack_i          (ack_i[k]),
            .state_o        (chan_state[k]),
            .busy_nxt_o     (chan_busy_nxt[k]),
            .adc_start_o    (adc_start_o[k]),
            .readout_o      (readout_o[k]),
            .done_o         (done_o[k]),
            .nrun_o         (nrun_o[k]),
            .timeout_o      (timeout_o[k]),
            .overrun_o      (overrun_o[k])
        );
    end

    // Grant selection: nearest pending channel at/after the pointer while the
    // shared ADC is free, or every pending channel when converters are private.
    always_comb begin
        grant      = '0;
        rr_nxt     = rr_ptr;
        any_active = 1'b0;
        best       = 0;
        best_d     = NUM_LAB;
        for (int j = 0; j < NUM_LAB; j++) begin
            if (chan_state[j] == ST_ADC || chan_state[j] == ST_READ) any_active = 1'b1;
            if (chan_state[j] == ST_PEND && rr_dist(j, rr_ptr) < best_d) begin
                best_d = rr_dist(j, rr_ptr);
                best   = j;
            end
        end
        if (SHARED_ADC != 0) begin
            if (!any_active && best_d < NUM_LAB) begin
                for (int j = 0; j < NUM_LAB; j++) grant[j] = (j == best);
                rr_nxt = CH_W'((best + 1) % NUM_LAB);
            end
        end else begin
            for (int j = 0; j < NUM_LAB; j++) grant[j] = (chan_state[j] == ST_PEND);
        end
    end

    // Round-robin pointer and aggregate busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            busy_o <= 1'b0;
        end else begin
            rr_ptr <= rr_nxt;
            busy_o <= |chan_busy_nxt;
        end
    end

    assign ram_raddr_o = addr_i[RAM_AW-1:0];

    // p0 -> p1: capture read strobe and channel select while the RAM reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_i;
        end
        sel_p1 <= addr_i[CH_W+RAM_AW-1:RAM_AW];
    end

    // Channel mux over the RAM words; unpopulated channels read as zero.
    always_comb begin
        rd_word_p1 = '0;
        for (int k = 0; k < NUM_LAB; k++) begin
            if (sel_p1 == CH_W'(k)) rd_word_p1 = ram_dat_i[32*k +: 32];
        end
    end

    // p1 -> p2: register the selected word and its valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
        end else begin
            dat_valid_o <= vld_p1;
            if (vld_p1) dat_o <= rd_word_p1;
        end
    end

endmodule

// File: tb/tb_lab_readout_sequencer.sv
// Directed bench for lab_readout_sequencer (4 channels, shared ADC, 16-cycle timeout).
module tb_lab_readout_sequencer;

    localparam int NUM_LAB = 4;
    localparam int CH_W    = 2;
    localparam int RAM_AW  = 11;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_LAB-1:0]     hold, dig, adone, rdone, ack;
    logic [NUM_LAB-1:0]     adc_start, readout, nrun, done, timeout, overrun;
    logic [RAM_AW-1:0]      raddr;
    logic [32*NUM_LAB-1:0]  ram_dat;
    logic [CH_W+RAM_AW-1:0] addr;
    logic                   rd;
    logic [31:0]            dat;
    logic                   dat_valid;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    lab_readout_sequencer #(
        .NUM_LAB(NUM_LAB), .CH_W(CH_W), .RAM_AW(RAM_AW),
        .SHARED_ADC(1), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .digitize_i(dig),
        .adc_start_o(adc_start), .adc_done_i(adone), .readout_o(readout),
        .readout_done_i(rdone), .nrun_o(nrun), .ram_raddr_o(raddr),
        .ram_dat_i(ram_dat), .addr_i(addr), .rd_i(rd), .dat_o(dat),
        .dat_valid_o(dat_valid), .done_o(done), .ack_i(ack), .busy_o(busy),
        .timeout_o(timeout), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle latency, word = (channel << 16) | address.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_LAB; k++)
            ram_dat[32*k +: 32] <= (32'(k) << 16) | 32'(raddr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] hold, dig, adone, rdone, ack;
        logic [3:0] e_start, e_rdo, e_done, e_nrun, e_ovr;
        logic       e_busy;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input logic [3:0] h, d, ad, rdn, a,
                                input logic [3:0] s, r, dn, n, o, input logic b);
        vec_t v;
        v.hold = h; v.dig = d; v.adone = ad; v.rdone = rdn; v.ack = a;
        v.e_start = s; v.e_rdo = r; v.e_done = dn; v.e_nrun = n; v.e_ovr = o; v.e_busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hold = '0; dig = '0; adone = '0; rdone = '0; ack = '0; rd = 1'b0; addr = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " adc_start"}, 32'(adc_start), 0);
        chk({tag, " readout"},   32'(readout), 0);
        chk({tag, " nrun"},      32'(nrun), 0);
        chk({tag, " done"},      32'(done), 0);
        chk({tag, " busy"},      32'(busy), 0);
        chk({tag, " timeout"},   32'(timeout), 0);
        chk({tag, " overrun"},   32'(overrun), 0);
        chk({tag, " dat"},       dat, 0);
        chk({tag, " dat_valid"}, 32'(dat_valid), 0);
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");

        // Reset mid-ADC aborts the conversion; a late adc_done gives no readout.
        rst = 1'b0;
        dig = 4'b0010;
        tick();
        dig = '0;
        tick();
        chk("rst_mid start1", 32'(adc_start), 32'h2);
        hold = 4'b1111;
        rst  = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        rst   = 1'b0;
        hold  = '0;
        adone = 4'b0010;
        tick();
        adone = '0;
        chk("rst_mid stray readout a", 32'(readout), 0);
        tick();
        chk("rst_mid stray readout b", 32'(readout), 0);
        chk("rst_mid busy", 32'(busy), 0);

        // Single event on channel 2, plus hold passthrough and stray pulses in IDLE.
        do_reset();
        tbl[0] = mk(4'b0001, 0, 0, 0, 0,       0, 0, 0, 4'b0001, 0, 0);
        tbl[1] = mk(0, 4'b0100, 0, 0, 0,       0, 0, 0, 0, 0, 1);
        tbl[2] = mk(0, 0, 0, 0, 0,             4'b0100, 0, 0, 4'b0100, 0, 1);
        tbl[3] = mk(0, 0, 0, 0, 0,             0, 0, 0, 4'b0100, 0, 1);
        tbl[4] = mk(0, 0, 4'b0100, 0, 0,       0, 4'b0100, 0, 4'b0100, 0, 1);
        tbl[5] = mk(0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 1);
        tbl[6] = mk(0, 0, 0, 4'b0100, 0,       0, 0, 4'b0100, 0, 0, 1);
        tbl[7] = mk(0, 0, 0, 0, 4'b0100,       0, 0, 0, 0, 0, 0);
        tbl[8] = mk(0, 0, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            hold = tbl[i].hold; dig = tbl[i].dig; adone = tbl[i].adone;
            rdone = tbl[i].rdone; ack = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d adc_start", i), 32'(adc_start), 32'(tbl[i].e_start));
            chk($sformatf("vec%0d readout", i),   32'(readout),   32'(tbl[i].e_rdo));
            chk($sformatf("vec%0d done", i),      32'(done),      32'(tbl[i].e_done));
            chk($sformatf("vec%0d nrun", i),      32'(nrun),      32'(tbl[i].e_nrun));
            chk($sformatf("vec%0d overrun", i),   32'(overrun),   32'(tbl[i].e_ovr));
            chk($sformatf("vec%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
        end
        clr_in();

        // Round-robin: all four request together, served 0..3, one at a time.
        do_reset();
        dig = 4'b1111;
        tick();
        dig = '0;
        tick();
        for (int k = 0; k < NUM_LAB; k++) begin
            chk($sformatf("rr start%0d", k), 32'(adc_start), 32'(1) << k);
            adone = 4'(1 << k);
            tick();
            adone = '0;
            chk($sformatf("rr readout%0d", k), 32'(readout), 32'(1) << k);
            chk($sformatf("rr quiet_a%0d", k), 32'(adc_start), 0);
            rdone = 4'(1 << k);
            tick();
            rdone = '0;
            chk($sformatf("rr done%0d", k), 32'(done[k]), 1);
            chk($sformatf("rr quiet_b%0d", k), 32'(adc_start), 0);
            tick();
        end
        chk("rr all done", 32'(done), 32'hF);
        ack = 4'b1111;
        tick();
        ack = '0;
        chk("rr busy after ack", 32'(busy), 0);

        // Timeout: adc_done withheld on channel 0.
        do_reset();
        dig = 4'b0001;
        tick();
        dig = '0;
        tick();
        chk("to start0", 32'(adc_start), 32'h1);
        repeat (15) tick();
        chk("to done@15", 32'(done), 0);
        chk("to flag@15", 32'(timeout), 0);
        tick();
        chk("to done@16", 32'(done), 32'h1);
        chk("to flag@16", 32'(timeout), 32'h1);
        ack = 4'b0001;
        tick();
        ack = '0;
        chk("to flag cleared", 32'(timeout), 0);
        chk("to busy cleared", 32'(busy), 0);

        // Overrun in READ, then re-arm from DONE with a simultaneous ack.
        do_reset();
        dig = 4'b1000;
        tick();
        dig = '0;
        tick();
        chk("ov start3", 32'(adc_start), 32'h8);
        adone = 4'b1000;
        tick();
        adone = '0;
        chk("ov readout3", 32'(readout), 32'h8);
        dig = 4'b1000;
        tick();
        dig = '0;
        chk("ov flag set", 32'(overrun), 32'h8);
        chk("ov no done", 32'(done), 0);
        chk("ov no restart", 32'(adc_start), 0);
        rdone = 4'b1000;
        tick();
        rdone = '0;
        chk("ov done3", 32'(done), 32'h8);
        dig = 4'b1000;
        ack = 4'b1000;
        tick();
        dig = '0;
        ack = '0;
        chk("rearm done low", 32'(done), 0);
        chk("rearm flag kept", 32'(overrun), 32'h8);
        chk("rearm busy", 32'(busy), 1);
        tick();
        chk("rearm start3", 32'(adc_start), 32'h8);
        ack = 4'b1000;
        tick();
        ack = '0;
        chk("ack clears flag", 32'(overrun), 0);
        chk("ack keeps busy", 32'(busy), 1);

        // Readback pipeline: two back-to-back reads.
        do_reset();
        rd   = 1'b1;
        addr = {2'd1, 11'h005};
        #1;
        chk("raddr comb", 32'(raddr), 32'h005);
        tick();
        chk("rb valid c1", 32'(dat_valid), 0);
        addr = {2'd3, 11'h7FF};
        tick();
        rd   = 1'b0;
        addr = '0;
        chk("rb valid c2", 32'(dat_valid), 1);
        chk("rb data c2", dat, 32'h0001_0005);
        tick();
        chk("rb valid c3", 32'(dat_valid), 1);
        chk("rb data c3", dat, 32'h0003_07FF);
        tick();
        chk("rb valid c4", 32'(dat_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
